// File: rtl/ccff_chain_loader.sv
// Purpose: serialises bitstream words LSB-first onto one tile's ccff chain; optional readback via CCFF_CHAIN_LOADER_READBACK_EN.
// Latency: ceil(CHAIN_LEN/WORD_W) fetch cycles + CHAIN_LEN shift cycles, then a 1-cycle done pulse (+CHAIN_LEN with readback).
// Backpressure: s_ready only in FETCH (no prefetch); the chain holds while s_valid is low; abort wins over everything.
module ccff_chain_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 18,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [WORD_W-1:0] s_data,
   output logic              s_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int                WL_W      = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [WL_W-1:0]   WORD_BITS = WL_W'(WORD_W);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_CHECK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;
`endif

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   shreg_q;
   logic [WL_W-1:0]     word_left_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic                bit_last;

   // bit_cnt counts chain bits in SHIFT (and recirculated bits in CHECK)
   assign bit_last = (bit_cnt_q == LAST_BIT);
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE) && !abort;

   // State register
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // Next-state and chain/stream outputs; abort overrides every transition and qualifier
   always_comb begin
      state_d       = state_q;
      s_ready       = 1'b0;
      ccff_shift_en = 1'b0;
      ccff_head     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            s_ready = 1'b1;
            if (s_valid) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            ccff_shift_en = 1'b1;
            ccff_head     = shreg_q[0];
            if (bit_last) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else if (word_left_q == WL_W'(1)) begin
               state_d = S_FETCH;
            end
         end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
         S_CHECK: begin
            // recirculate tail into head so the chain ends where it started
            ccff_shift_en = 1'b1;
            ccff_head     = ccff_tail;
            if (bit_last) state_d = S_DONE;
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort) begin
         state_d       = S_IDLE;
         s_ready       = 1'b0;
         ccff_shift_en = 1'b0;
      end
   end

   // Word shift register, bits-left-in-word and chain bit counter
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         shreg_q     <= '0;
         word_left_q <= '0;
         bit_cnt_q   <= '0;
      end else if (!abort) begin
         case (state_q)
            S_IDLE: begin
               if (start) bit_cnt_q <= '0;
            end
            S_FETCH: begin
               if (s_valid) begin
                  shreg_q     <= s_data;
                  word_left_q <= WORD_BITS;
               end
            end
            S_SHIFT: begin
               shreg_q     <= shreg_q >> 1;
               word_left_q <= word_left_q - 1'b1;
               // wrap at the last bit so a following CHECK pass counts from zero
               bit_cnt_q   <= bit_last ? '0 : bit_cnt_q + 1'b1;
            end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
            S_CHECK: begin
               bit_cnt_q <= bit_last ? '0 : bit_cnt_q + 1'b1;
            end
`endif
            default: begin
            end
         endcase
      end
   end

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
   logic [7:0] crc_tx_q;
   logic [7:0] crc_rx_q;
   logic [7:0] crc_rx_nxt;
   logic       err_q;

   // serial CRC-8, polynomial x^8+x^2+x+1 (0x07)
   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
      logic fb;
      fb = c[7] ^ b;
      return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   assign crc_rx_nxt = crc8_step(crc_rx_q, ccff_tail);
   assign err        = err_q;

   // CRC of bits sent, CRC of bits read back, and the sticky mismatch flag
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         crc_tx_q <= '0;
         crc_rx_q <= '0;
         err_q    <= 1'b0;
      end else if (!abort) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  crc_tx_q <= '0;
                  crc_rx_q <= '0;
                  err_q    <= 1'b0;
               end
            end
            S_SHIFT: begin
               crc_tx_q <= crc8_step(crc_tx_q, shreg_q[0]);
            end
            S_CHECK: begin
               crc_rx_q <= crc_rx_nxt;
               if (bit_last) err_q <= err_q | (crc_rx_nxt != crc_tx_q);
            end
            default: begin
            end
         endcase
      end
   end
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

   localparam int WORD_W    = 8;
   localparam int CHAIN_LEN = 18;
   localparam int CNT_W     = 16;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
   localparam int RB_EXTRA  = CHAIN_LEN;
`else
   localparam int RB_EXTRA  = 0;
`endif
   // done appears in the cycle after the 21st edge following the start edge
   localparam int          DONE_CYC  = 21 + RB_EXTRA;
   // chain[17] holds the first bit shifted (bit0 of 0xA5), chain[0] the last
   localparam logic [17:0] CHAIN_EXP = 18'h294F3;

   logic              prog_clk = 1'b0;
   logic              pReset_n = 1'b0;
   logic              start    = 1'b0;
   logic              abort    = 1'b0;
   logic              s_valid  = 1'b0;
   logic [WORD_W-1:0] s_data   = '0;
   logic              s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [17:0] chain = '0;
   logic        flip  = 1'b0;
   int          hs_cnt = 0;
   int          done_cnt = 0;
   logic [7:0]  words [4];

   ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
      .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .abort(abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .ccff_head(ccff_head),
      .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy),
      .done(done), .err(err)
   );

   always #5 prog_clk = ~prog_clk;

   // chain model: tail wired back for readback; flip injects a single bit error
   assign ccff_tail = chain[17];
   always @(posedge prog_clk) begin
      if (ccff_shift_en) chain <= {chain[16:0], ccff_head} ^ (flip ? 18'h00400 : 18'h0);
      if (s_valid && s_ready) hs_cnt = hs_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge prog_clk);
      start = 1'b1;
      @(posedge prog_clk);
      #1 start = 1'b0;
   endtask

   // full load with s_valid high except 'stall' FETCH cycles before word 2
   task automatic do_load(input int stall, input int flip_at, output int done_cyc);
      int w, gap;
      logic hs;
      logic [17:0] snap;
      w = 0; gap = 0; done_cyc = -1; snap = '0;
      pulse_start();
      for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
         @(negedge prog_clk);
         flip = (cyc == flip_at);
         if (w == 1 && gap < stall && s_ready) begin
            s_valid = 1'b0;
            if (gap == 0) snap = chain;
            else check("stall_chain_hold", chain, snap);
            check("stall_shift_en", ccff_shift_en, 0);
            gap++;
         end else begin
            s_valid = (w < 3);
            s_data  = words[w];
         end
         #1;
         if (done) done_cyc = cyc;
         hs = s_valid && s_ready;
         @(posedge prog_clk);
         if (hs) w++;
      end
      #1;
      flip = 1'b0;
      s_valid = 1'b0;
      if (done_cyc < 0) check("load_done_timeout", 0, 1);
   endtask

   typedef struct {
      logic       s_valid;
      logic [7:0] s_data;
      logic       rdy, sen, head, bsy, dn;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                               input logic se, input logic h, input logic b, input logic dn);
      vec_t x;
      x.s_valid = v; x.s_data = d; x.rdy = r; x.sen = se; x.head = h; x.bsy = b; x.dn = dn;
      return x;
   endfunction

   initial begin
      int dc, hs0, d0, seen;
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00;

      // per-cycle expectations of the basic load, cycle k = after the k-th edge from start
      tbl[0]  = mk(1, 8'hA5, 1, 0, 0, 1, 0);
      tbl[1]  = mk(1, 8'h00, 0, 1, 1, 1, 0);
      tbl[2]  = mk(1, 8'h00, 0, 1, 0, 1, 0);
      tbl[3]  = mk(1, 8'h00, 0, 1, 1, 1, 0);
      tbl[4]  = mk(1, 8'h00, 0, 1, 0, 1, 0);
      tbl[5]  = mk(1, 8'h00, 0, 1, 0, 1, 0);
      tbl[6]  = mk(1, 8'h00, 0, 1, 1, 1, 0);
      tbl[7]  = mk(1, 8'h00, 0, 1, 0, 1, 0);
      tbl[8]  = mk(1, 8'h00, 0, 1, 1, 1, 0);
      tbl[9]  = mk(1, 8'h3C, 1, 0, 0, 1, 0);
      tbl[10] = mk(1, 8'h00, 0, 1, 0, 1, 0);
      tbl[11] = mk(1, 8'h00, 0, 1, 0, 1, 0);
      tbl[12] = mk(1, 8'h00, 0, 1, 1, 1, 0);
      tbl[13] = mk(1, 8'h00, 0, 1, 1, 1, 0);
      tbl[14] = mk(1, 8'h00, 0, 1, 1, 1, 0);
      tbl[15] = mk(1, 8'h00, 0, 1, 1, 1, 0);
      tbl[16] = mk(1, 8'h00, 0, 1, 0, 1, 0);
      tbl[17] = mk(1, 8'h00, 0, 1, 0, 1, 0);
      tbl[18] = mk(1, 8'hFF, 1, 0, 0, 1, 0);
      tbl[19] = mk(1, 8'h00, 0, 1, 1, 1, 0);
      tbl[20] = mk(1, 8'h00, 0, 1, 1, 1, 0);

      // reset state
      #23;
      check("rst_s_ready", s_ready, 0);
      check("rst_shift_en", ccff_shift_en, 0);
      check("rst_head", ccff_head, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      @(negedge prog_clk);
      pReset_n = 1'b1;
      s_valid  = 1'b1;
      @(negedge prog_clk);
      check("idle_s_ready", s_ready, 0);

      // start together with abort in IDLE is ignored
      start = 1'b1; abort = 1'b1;
      @(posedge prog_clk);
      #1 start = 1'b0; abort = 1'b0;
      @(negedge prog_clk);
      check("start_abort_idle_busy", busy, 0);

      // basic load, table driven
      hs0 = hs_cnt; d0 = done_cnt;
      pulse_start();
      for (int k = 0; k < 21; k++) begin
         @(negedge prog_clk);
         s_valid = tbl[k].s_valid;
         s_data  = tbl[k].s_data;
         #1;
         check($sformatf("vec%0d_s_ready", k), s_ready, tbl[k].rdy);
         check($sformatf("vec%0d_shift_en", k), ccff_shift_en, tbl[k].sen);
         if (tbl[k].sen) check($sformatf("vec%0d_head", k), ccff_head, tbl[k].head);
         check($sformatf("vec%0d_busy", k), busy, tbl[k].bsy);
         check($sformatf("vec%0d_done", k), done, tbl[k].dn);
      end
      seen = -1;
      for (int cyc = 21; cyc < 80 && seen < 0; cyc++) begin
         @(negedge prog_clk);
         #1;
         if (done) seen = cyc;
      end
      repeat (2) @(negedge prog_clk);
      check("basic_done_cycle", seen, DONE_CYC);
      check("basic_done_count", done_cnt - d0, 1);
      check("basic_handshakes", hs_cnt - hs0, 3);
      check("basic_chain", chain, CHAIN_EXP);
      check("basic_err", err, 0);
      check("basic_idle_busy", busy, 0);
      s_valid = 1'b0;

      // stalled source: 5 empty FETCH cycles before word 2
      do_load(5, -1, dc);
      check("stall_done_cycle", dc, DONE_CYC + 5);
      check("stall_chain", chain, CHAIN_EXP);

      // abort on the 4th SHIFT cycle of word 2
      d0 = done_cnt;
      pulse_start();
      for (int cyc = 0; cyc < 13; cyc++) begin
         @(negedge prog_clk);
         s_valid = 1'b1;
         s_data  = (cyc == 0) ? 8'hA5 : (cyc == 9) ? 8'h3C : 8'h00;
      end
      @(negedge prog_clk);
      abort = 1'b1;
      #1;
      check("abort_cycle_shift_en", ccff_shift_en, 0);
      check("abort_cycle_s_ready", s_ready, 0);
      @(posedge prog_clk);
      #1 abort = 1'b0;
      @(negedge prog_clk);
      check("abort_busy", busy, 0);
      check("abort_s_ready", s_ready, 0);
      repeat (25) @(negedge prog_clk);
      check("abort_no_done", done_cnt - d0, 0);
      s_valid = 1'b0;

      // abort in FETCH: same-cycle handshake must not be taken
      pulse_start();
      @(negedge prog_clk);
      s_valid = 1'b1; s_data = 8'hA5; abort = 1'b1;
      hs0 = hs_cnt;
      #1;
      check("abort_fetch_s_ready", s_ready, 0);
      @(posedge prog_clk);
      #1 abort = 1'b0;
      @(negedge prog_clk);
      check("abort_fetch_handshake", hs_cnt - hs0, 0);
      check("abort_fetch_busy", busy, 0);
      s_valid = 1'b0;

      // clean reload after abort
      do_load(0, -1, dc);
      check("reload_done_cycle", dc, DONE_CYC);
      check("reload_chain", chain, CHAIN_EXP);

      // reset in the middle of SHIFT
      pulse_start();
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge prog_clk);
         s_valid = 1'b1;
         s_data  = 8'hA5;
      end
      @(negedge prog_clk);
      pReset_n = 1'b0;
      #1;
      check("rst_mid_shift_en", ccff_shift_en, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_s_ready", s_ready, 0);
      check("rst_mid_done", done, 0);
      @(negedge prog_clk);
      pReset_n = 1'b1;
      hs0 = hs_cnt;
      repeat (5) @(negedge prog_clk);
      check("rst_after_busy", busy, 0);
      check("rst_after_s_ready", s_ready, 0);
      check("rst_after_handshake", hs_cnt - hs0, 0);
      s_valid = 1'b0;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      // readback with a bit flipped in the chain during CHECK
      do_load(0, 25, dc);
      check("rb_fail_done_cycle", dc, DONE_CYC);
      check("rb_fail_err", err, 1);
      repeat (4) @(negedge prog_clk);
      check("rb_fail_err_sticky", err, 1);
      pulse_start();
      check("rb_err_cleared_by_start", err, 0);
      @(negedge prog_clk);
      abort = 1'b1;
      @(posedge prog_clk);
      #1 abort = 1'b0;
`else
      check("no_rb_err", err, 0);
`endif

      repeat (2) @(negedge prog_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
